// File: rtl/fifo_serial_tx.sv
// Drains a first-word-fall-through FIFO onto a serial line.
// Each frame is a start bit, data LSB first, optional even parity, then one stop bit.
//   state  | meaning
//   IDLE   | line high, waiting for a non-empty FIFO
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | even parity over the data bits
//   STOP   | stop bit; may pop the next word for a back-to-back frame
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_r_data,
    output logic                  o_fifo_rd,
    output logic                  o_tx,
    output logic                  o_busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_bit_cnt;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_par;

    state_t                w_state_next;
    logic [CW-1:0]         w_bit_cnt_next;
    logic [IW-1:0]         w_idx_next;
    logic [DATA_WIDTH-1:0] w_shreg_next;
    logic                  w_par_next;
    logic                  w_rd;
    logic                  w_bit_end;
    logic                  w_tx_next;

    assign w_bit_end = (r_bit_cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = w_bit_end ? '0 : r_bit_cnt + CW'(1);
        w_idx_next     = r_idx;
        w_shreg_next   = r_shreg;
        w_par_next     = r_par;
        w_rd           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_bit_cnt_next = '0;
                if (!i_fifo_empty) begin
                    w_rd         = 1'b1;
                    w_shreg_next = i_fifo_r_data;
                    w_idx_next   = '0;
                    w_par_next   = 1'b0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shreg_next = r_shreg >> 1;
                    w_par_next   = r_par ^ r_shreg[0];
                    if (r_idx == IW'(DATA_WIDTH - 1)) begin
                        w_idx_next   = '0;
                        w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_idx_next = r_idx + IW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (!i_fifo_empty) begin
                        w_rd         = 1'b1;
                        w_shreg_next = i_fifo_r_data;
                        w_idx_next   = '0;
                        w_par_next   = 1'b0;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Line level is registered alongside the state, so derive it from the next state.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shreg_next[0];
            ST_PARITY: w_tx_next = w_par_next;
            default:   w_tx_next = 1'b1;
        endcase
    end

    assign o_fifo_rd = w_rd & ~i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_shreg   <= '0;
            r_par     <= 1'b0;
            o_tx      <= 1'b1;
            o_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_idx     <= w_idx_next;
            r_shreg   <= w_shreg_next;
            r_par     <= w_par_next;
            o_tx      <= w_tx_next;
            o_busy    <= (w_state_next != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: one default instance and one with even parity enabled.
// Expected line patterns are hand-written as {stop, [parity,] data, start}, start bit in bit 0.
module tb_fifo_serial_tx;
    localparam int CPB = 4;

    logic       clk;
    logic       rst0, empty0, rd0, tx0, busy0;
    logic [7:0] data0;
    logic       rst1, empty1, rd1, tx1, busy1;
    logic [7:0] data1;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_serial_tx dut0 (
        .i_clk(clk), .i_reset(rst0), .i_fifo_empty(empty0), .i_fifo_r_data(data0),
        .o_fifo_rd(rd0), .o_tx(tx0), .o_busy(busy0)
    );

    fifo_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .i_clk(clk), .i_reset(rst1), .i_fifo_empty(empty1), .i_fifo_r_data(data1),
        .o_fifo_rd(rd1), .o_tx(tx1), .o_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [7:0]  word;
        logic [10:0] exp_line;
        int          nbits;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic rst, input logic empty, input logic [7:0] data);
        if (sel) begin
            rst1 = rst; empty1 = empty; data1 = data;
        end else begin
            rst0 = rst; empty0 = empty; data0 = data;
        end
    endtask

    task automatic check_out(input string name, input logic sel,
                             input logic e_rd, input logic e_tx, input logic e_busy);
        #1;
        chk({name, "_rd"},   sel ? rd1 : rd0,     e_rd);
        chk({name, "_tx"},   sel ? tx1 : tx0,     e_tx);
        chk({name, "_busy"}, sel ? busy1 : busy0, e_busy);
    endtask

    // popped=1: the pop for this word already happened in the previous STOP cycle
    task automatic send_frame(input logic sel, input logic [7:0] word, input logic [10:0] exp_line,
                              input int nbits, input logic popped, input logic b2b,
                              input logic [7:0] nxt);
        logic last;
        if (!popped) begin
            tick();
            drive(sel, 1'b0, 1'b0, word);
            check_out("pop", sel, 1'b1, 1'b1, 1'b0);
        end
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < CPB; c++) begin
                tick();
                last = (k == nbits - 1) && (c == CPB - 1);
                if (last && b2b) drive(sel, 1'b0, 1'b0, nxt);
                else             drive(sel, 1'b0, 1'b1, 8'h00);
                check_out("line", sel, last && b2b, exp_line[k], 1'b1);
            end
        end
    endtask

    task automatic idle_check(input logic sel);
        tick();
        drive(sel, 1'b0, 1'b1, 8'h00);
        check_out("idle", sel, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [10:0] exp5a;

        vecs[0] = '{1'b0, 8'hA5, 11'b0_1_10100101_0, 10};
        vecs[1] = '{1'b0, 8'h3C, 11'b0_1_00111100_0, 10};
        vecs[2] = '{1'b0, 8'h80, 11'b0_1_10000000_0, 10};
        vecs[3] = '{1'b0, 8'h01, 11'b0_1_00000001_0, 10};
        vecs[4] = '{1'b1, 8'h07, 11'b1_1_00000111_0, 11};
        vecs[5] = '{1'b1, 8'h03, 11'b1_0_00000011_0, 11};
        vecs[6] = '{1'b1, 8'hFF, 11'b1_0_11111111_0, 11};
        vecs[7] = '{1'b1, 8'h80, 11'b1_1_10000000_0, 11};

        // reset held with a non-empty FIFO must neither pop nor start a frame
        drive(1'b0, 1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b1, 1'b0, 8'h55);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("rst_hold", 1'b0, 1'b0, 1'b1, 1'b0);
            check_out("rst_hold_p", 1'b1, 1'b0, 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        idle_check(1'b0);
        idle_check(1'b1);

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].sel, vecs[v].word, vecs[v].exp_line, vecs[v].nbits, 1'b0, 1'b0, 8'h00);
            idle_check(vecs[v].sel);
        end

        // back-to-back 0x00 then 0xFF: second pop in cycle 40, busy never drops
        send_frame(1'b0, 8'h00, 11'b0_1_00000000_0, 10, 1'b0, 1'b1, 8'hFF);
        send_frame(1'b0, 8'hFF, 11'b0_1_11111111_0, 10, 1'b1, 1'b0, 8'h00);
        idle_check(1'b0);

        // one-cycle reset at cycle 12 of a 0x5A frame, FIFO still non-empty
        exp5a = 11'b0_1_01011010_0;
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h5A);
        check_out("r5a_pop", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            tick();
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            check_out("r5a_line", 1'b0, 1'b0, exp5a[(c - 1) / CPB], 1'b1);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h77);
        #1;
        chk("midrst_rd", rd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h77);
        check_out("post_rst_pop", 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(1'b0, 8'h77, 11'b0_1_01110111_0, 10, 1'b1, 1'b0, 8'h00);
        idle_check(1'b0);

        // long empty stretch, word appears at cycle 50
        for (int c = 0; c < 50; c++) begin
            tick();
            drive(1'b0, 1'b0, 1'b1, 8'hEE);
            check_out("empty_wait", 1'b0, 1'b0, 1'b1, 1'b0);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'hC3);
        check_out("late_pop", 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(1'b0, 8'hC3, 11'b0_1_11000011_0, 10, 1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 49; c++) idle_check(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
